// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pkg                                                                 |
// | Shared core defaults and register-file clear-engine state encoding.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package core_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_clr_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_scoreboard                                                            |
// | Per-register pending-write bits: set on claim, cleared on writeback.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_all_i,
    input  logic          wb_en_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          claim_en_i,
    input  logic [AW-1:0] claim_addr_i,
    input  logic [AW-1:0] rd1_addr_i,
    input  logic [AW-1:0] rd2_addr_i,
    output logic          rd1_busy_o,
    output logic          rd2_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Claim is applied after writeback so a same-address pair leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_all_i) begin
            busy_d = '0;
        end else begin
            if (wb_en_i) begin
                busy_d[wb_addr_i] = 1'b0;
            end
            if (claim_en_i) begin
                busy_d[claim_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd1_busy_o = (int'(rd1_addr_i) < NREGS) ? busy_q[rd1_addr_i] : 1'b0;
    assign rd2_busy_o = (int'(rd2_addr_i) < NREGS) ? busy_q[rd2_addr_i] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_sb                                                              |
// | 2R/1W register file with write bypass, scoreboard and sequential clear.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module reg_file_sb
    import core_pkg::*;
#(
    parameter int  XLEN    = XLEN_DEFAULT,
    parameter int  NREGS   = NREGS_DEFAULT,
    parameter bit  ZERO_X0 = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            claim_en,
    input  logic [AW-1:0]   claim_addr,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    localparam logic [AW-1:0] c_last_idx = AW'(NREGS - 1);

    // An address is live when it exists and is not the hardwired-zero x0.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_X0 && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    rf_clr_state_e   state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            clr_start;
    logic            w_idle, w_wr_ok, w_claim_ok, w_hit1, w_hit2;
    logic            w_raw_busy1, w_raw_busy2;

    assign w_idle     = (state_q == RF_IDLE);
    assign w_wr_ok    = wr_en && w_idle && addr_live(wr_addr);
    assign w_claim_ok = claim_en && w_idle && addr_live(claim_addr);
    assign w_hit1     = w_wr_ok && (wr_addr == rs1_addr);
    assign w_hit2     = w_wr_ok && (wr_addr == rs2_addr);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr_start = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    idx_d     = '0;
                    clr_start = 1'b1;
                end
            end
            RF_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == c_last_idx) begin
                    state_d = RF_DONE;
                end
            end
            RF_DONE: state_d = RF_IDLE;
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == RF_CLEAR) begin
            regs_q[idx_q] <= '0;
        end else if (w_wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_all_i    (clr_start),
        .wb_en_i      (w_wr_ok),
        .wb_addr_i    (wr_addr),
        .claim_en_i   (w_claim_ok),
        .claim_addr_i (claim_addr),
        .rd1_addr_i   (rs1_addr),
        .rd2_addr_i   (rs2_addr),
        .rd1_busy_o   (w_raw_busy1),
        .rd2_busy_o   (w_raw_busy2)
    );

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (addr_live(rs1_addr)) begin
            rs1_data = w_hit1 ? wr_data : regs_q[rs1_addr];
        end
        if (addr_live(rs2_addr)) begin
            rs2_data = w_hit2 ? wr_data : regs_q[rs2_addr];
        end
    end

    assign rs1_busy = addr_live(rs1_addr) && w_raw_busy1 && !w_hit1;
    assign rs2_busy = addr_live(rs2_addr) && w_raw_busy2 && !w_hit2;
    assign clr_busy = (state_q == RF_CLEAR);
    assign clr_done = (state_q == RF_DONE);

endmodule
`default_nettype wire
